// File: rtl/fetch_queue_unit_if.sv
// Fetch-stage bus: instruction-memory request/response, branch redirect and decode-side queue head.
// The master modport is the fetch unit; the slave modport is the surrounding pipeline/memory.
interface fetch_queue_unit_if #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4
);
   localparam int OW = $clog2(DEPTH) + 1;

   logic            imem_req_valid;
   logic [XLEN-1:0] imem_req_addr;
   logic            imem_req_ready;
   logic            imem_resp_valid;
   logic [31:0]     imem_resp_data;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            out_valid;
   logic [31:0]     out_instr;
   logic [XLEN-1:0] out_pc_plus4;
   logic            out_ready;
   logic [OW-1:0]   occupancy;

   modport master (
      output imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc_plus4, occupancy,
      input  imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc, out_ready
   );

   modport slave (
      input  imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc_plus4, occupancy,
      output imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc, out_ready
   );
endinterface

// File: rtl/fetch_queue_unit.sv
// Instruction-fetch stage: PC sequencer, credit-limited imem requests, in-flight address tags
// and an in-order prefetch queue feeding decode. Redirect flushes and marks in-flight fetches stale.
module fetch_queue_unit #(
   parameter int              XLEN     = 32,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter logic [31:0]     NOP      = 32'h0000_0000
) (
   input  logic                clock,
   input  logic                reset,
   fetch_queue_unit_if.master  bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW+1:0] DEPTH_W = (CW+2)'(DEPTH);

   logic [XLEN-1:0] fetch_pc;

   logic [31:0]     q_instr [DEPTH];
   logic [XLEN-1:0] q_pc4   [DEPTH];
   logic [AW-1:0]   q_rd;
   logic [AW-1:0]   q_wr;
   logic [CW-1:0]   q_cnt;

   logic [XLEN-1:0] tag_addr [DEPTH];
   logic [AW-1:0]   tag_rd;
   logic [AW-1:0]   tag_wr;

   logic [CW-1:0]   live;
   logic [CW-1:0]   stale;
   logic [CW-1:0]   outstanding;
   logic [CW+1:0]   credit_sum;

   logic            req_fire;
   logic            resp_drop;
   logic            resp_keep;
   logic            pop;
   logic            flush_dec;

   // Every queue slot is reserved by either a held entry or an outstanding fetch, so pushes never overflow.
   assign credit_sum  = {2'b00, q_cnt} + {2'b00, live} + {2'b00, stale};
   assign outstanding = live + stale;

   assign bus.imem_req_valid = reset && !bus.redirect_valid && (credit_sum < DEPTH_W);
   assign bus.imem_req_addr  = fetch_pc;

   assign req_fire  = bus.imem_req_valid && bus.imem_req_ready;
   assign resp_drop = bus.imem_resp_valid && (stale != '0);
   assign resp_keep = bus.imem_resp_valid && (stale == '0) && (live != '0) && !bus.redirect_valid;
   assign pop       = (q_cnt != '0) && bus.out_ready && !bus.redirect_valid;
   assign flush_dec = bus.imem_resp_valid && (outstanding != '0);

   assign bus.out_valid    = (q_cnt != '0);
   assign bus.out_instr    = (q_cnt != '0) ? q_instr[q_rd] : NOP;
   assign bus.out_pc_plus4 = (q_cnt != '0) ? q_pc4[q_rd] : '0;
   assign bus.occupancy    = q_cnt;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         fetch_pc <= RESET_PC;
         q_rd     <= '0;
         q_wr     <= '0;
         q_cnt    <= '0;
         tag_rd   <= '0;
         tag_wr   <= '0;
         live     <= '0;
         stale    <= '0;
      end else if (bus.redirect_valid) begin
         // A response landing in the redirect cycle retires one of the now-stale fetches.
         fetch_pc <= {bus.redirect_pc[XLEN-1:2], 2'b00};
         q_rd     <= '0;
         q_wr     <= '0;
         q_cnt    <= '0;
         tag_rd   <= '0;
         tag_wr   <= '0;
         live     <= '0;
         stale    <= outstanding - CW'(flush_dec);
      end else begin
         if (req_fire) begin
            fetch_pc <= fetch_pc + XLEN'(4);
            tag_wr   <= tag_wr + AW'(1);
         end
         if (resp_keep) begin
            q_wr   <= q_wr + AW'(1);
            tag_rd <= tag_rd + AW'(1);
         end
         if (pop) begin
            q_rd <= q_rd + AW'(1);
         end
         if (resp_drop) begin
            stale <= stale - CW'(1);
         end
         q_cnt <= q_cnt + CW'(resp_keep) - CW'(pop);
         live  <= live + CW'(req_fire) - CW'(resp_keep);
      end
   end

   // Storage arrays carry no reset; q_cnt and the tag pointers qualify every read.
   always_ff @(posedge clock) begin
      if (req_fire) begin
         tag_addr[tag_wr] <= fetch_pc;
      end
      if (resp_keep) begin
         q_instr[q_wr] <= bus.imem_resp_data;
         q_pc4[q_wr]   <= tag_addr[tag_rd] + XLEN'(4);
      end
   end
endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit: in-order latency memory, queue-level reference model, per-cycle compare.
module tb_fetch_queue_unit;
   localparam int          XLEN     = 32;
   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP      = 32'h0000_0000;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   fetch_queue_unit_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus();

   fetch_queue_unit #(
      .XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC), .NOP(NOP)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   int tests = 0;
   int fails = 0;
   int cyc_n = 0;
   int lat   = 1;
   bit out_rdy = 1'b0;
   bit req_rdy = 1'b0;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } pend_t;
   pend_t pend[$];

   // reference model: queue contents, kept-fetch addresses, stale count, next fetch address
   logic [31:0] mq_instr[$];
   logic [31:0] mq_pc4[$];
   logic [31:0] m_live[$];
   int          m_stale = 0;
   logic [31:0] m_pc = RESET_PC;

   logic [31:0] acc_q[$];
   logic [31:0] pop_pc[$];
   logic [31:0] pop_ins[$];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hC0DE_0001;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc_n);
      end
   endtask

   task automatic clear_logs();
      acc_q.delete();
      pop_pc.delete();
      pop_ins.delete();
   endtask

   // called at a negedge; asserts reset asynchronously and checks outputs settle to reset values
   task automatic do_reset();
      reset                = 1'b0;
      bus.redirect_valid   = 1'b0;
      bus.redirect_pc      = '0;
      bus.imem_resp_valid  = 1'b0;
      bus.imem_resp_data   = '0;
      bus.imem_req_ready   = 1'b1;
      bus.out_ready        = 1'b1;
      pend.delete();
      mq_instr.delete();
      mq_pc4.delete();
      m_live.delete();
      m_stale = 0;
      m_pc    = RESET_PC;
      #1;
      chk("rst out_valid", 32'(bus.out_valid), 32'h0);
      chk("rst out_instr", bus.out_instr, NOP);
      chk("rst out_pc_plus4", bus.out_pc_plus4, 32'h0);
      chk("rst occupancy", 32'(bus.occupancy), 32'h0);
      chk("rst req_valid", 32'(bus.imem_req_valid), 32'h0);
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      cyc_n = 0;
      clear_logs();
   endtask

   // one clock cycle: drive at negedge, compare 1 time unit later, advance model and memory
   task automatic cyc(input bit rv, input logic [31:0] rpc);
      bit          resp;
      bit          exp_valid;
      bit          exp_req;
      bit          acc_m;
      bit          pop_m;
      int          outst;
      logic [31:0] rdata;
      logic [31:0] a;

      resp  = (pend.size() > 0) && (pend[0].due <= cyc_n);
      rdata = resp ? mem_word(pend[0].addr) : 32'hDEAD_BEEF;
      if (resp) void'(pend.pop_front());

      bus.redirect_valid  = rv;
      bus.redirect_pc     = rpc;
      bus.out_ready       = out_rdy;
      bus.imem_req_ready  = req_rdy;
      bus.imem_resp_valid = resp;
      bus.imem_resp_data  = rdata;
      #1;

      exp_valid = (mq_instr.size() > 0);
      exp_req   = !rv && ((mq_instr.size() + m_live.size() + m_stale) < DEPTH);
      chk("out_valid", 32'(bus.out_valid), 32'(exp_valid));
      chk("out_instr", bus.out_instr, exp_valid ? mq_instr[0] : NOP);
      chk("out_pc_plus4", bus.out_pc_plus4, exp_valid ? mq_pc4[0] : 32'h0);
      chk("occupancy", 32'(bus.occupancy), 32'(mq_instr.size()));
      chk("req_valid", 32'(bus.imem_req_valid), 32'(exp_req));
      chk("req_addr", bus.imem_req_addr, m_pc);

      if (bus.imem_req_valid && req_rdy) begin
         pend.push_back('{addr: bus.imem_req_addr, due: cyc_n + lat});
         acc_q.push_back(bus.imem_req_addr);
      end

      acc_m = exp_req && req_rdy;
      pop_m = exp_valid && out_rdy && !rv;
      if (rv) begin
         outst   = m_stale + m_live.size();
         m_stale = outst - ((resp && outst > 0) ? 1 : 0);
         m_live.delete();
         mq_instr.delete();
         mq_pc4.delete();
         m_pc = {rpc[31:2], 2'b00};
      end else begin
         if (pop_m) begin
            pop_pc.push_back(mq_pc4[0]);
            pop_ins.push_back(mq_instr[0]);
            void'(mq_instr.pop_front());
            void'(mq_pc4.pop_front());
         end
         if (resp) begin
            if (m_stale > 0) begin
               m_stale--;
            end else if (m_live.size() > 0) begin
               a = m_live.pop_front();
               mq_instr.push_back(rdata);
               mq_pc4.push_back(a + 32'd4);
            end
         end
         if (acc_m) begin
            m_live.push_back(m_pc);
            m_pc = m_pc + 32'd4;
         end
      end

      @(negedge clock);
      cyc_n++;
   endtask

   initial begin
      bit found;

      // startup, L = 1, both ready high
      lat = 1; req_rdy = 1'b1; out_rdy = 1'b1;
      do_reset();
      repeat (10) cyc(1'b0, 32'h0);
      chk("startup accepts", 32'(acc_q.size()), 32'd10);
      chk("startup pops", 32'(pop_pc.size()), 32'd8);
      chk("startup pc4 0", pop_pc[0], 32'h4);
      chk("startup pc4 1", pop_pc[1], 32'h8);
      chk("startup pc4 2", pop_pc[2], 32'hC);
      chk("startup instr 1", pop_ins[1], mem_word(32'h4));

      // stall: queue fills to DEPTH, fetch stops, then drains in order
      lat = 1; req_rdy = 1'b1; out_rdy = 1'b0;
      do_reset();
      repeat (8) cyc(1'b0, 32'h0);
      chk("stall accepts", 32'(acc_q.size()), 32'd4);
      chk("stall occupancy", 32'(bus.occupancy), 32'd4);
      chk("stall req_valid", 32'(bus.imem_req_valid), 32'h0);
      out_rdy = 1'b1;
      clear_logs();
      repeat (8) cyc(1'b0, 32'h0);
      chk("drain pc4 0", pop_pc[0], 32'h4);
      chk("drain pc4 1", pop_pc[1], 32'h8);
      chk("drain pc4 2", pop_pc[2], 32'hC);
      chk("drain pc4 3", pop_pc[3], 32'h10);
      chk("drain instr 3", pop_ins[3], mem_word(32'hC));
      chk("resume addr", acc_q[0], 32'h10);

      // redirect with two responses in flight, L = 3
      lat = 3; req_rdy = 1'b1; out_rdy = 1'b1;
      do_reset();
      repeat (2) cyc(1'b0, 32'h0);
      chk("inflight count", 32'(pend.size()), 32'd2);
      clear_logs();
      cyc(1'b1, 32'h0000_0103);
      repeat (14) cyc(1'b0, 32'h0);
      chk("redir first addr", acc_q[0], 32'h100);
      chk("redir first pc4", pop_pc[0], 32'h104);
      chk("redir first instr", pop_ins[0], mem_word(32'h100));

      // redirect, pop and response in the same cycle, L = 2
      lat = 2; req_rdy = 1'b1; out_rdy = 1'b1;
      do_reset();
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (mq_instr.size() > 0 && pend.size() > 0 && pend[0].due <= cyc_n) begin
            found = 1'b1;
            break;
         end
         cyc(1'b0, 32'h0);
      end
      chk("simul setup found", 32'(found), 32'h1);
      cyc(1'b1, 32'h0000_0200);
      chk("simul out_valid", 32'(bus.out_valid), 32'h0);
      chk("simul occupancy", 32'(bus.occupancy), 32'h0);
      clear_logs();
      repeat (10) cyc(1'b0, 32'h0);
      chk("simul first pc4", pop_pc[0], 32'h204);
      chk("simul first instr", pop_ins[0], mem_word(32'h200));

      // mid-operation reset with occupancy 3 and one live fetch
      lat = 1; req_rdy = 1'b1; out_rdy = 1'b0;
      do_reset();
      found = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (mq_instr.size() == 3 && m_live.size() == 1) begin
            found = 1'b1;
            break;
         end
         cyc(1'b0, 32'h0);
      end
      chk("midrst setup found", 32'(found), 32'h1);
      chk("midrst pre occupancy", 32'(bus.occupancy), 32'd3);
      #2;
      do_reset();
      out_rdy = 1'b1;
      repeat (4) cyc(1'b0, 32'h0);
      chk("midrst first addr", acc_q[0], RESET_PC);

      // address wrap at 2^32
      lat = 1; req_rdy = 1'b1; out_rdy = 1'b1;
      do_reset();
      repeat (3) cyc(1'b0, 32'h0);
      clear_logs();
      cyc(1'b1, 32'hFFFF_FFFC);
      repeat (8) cyc(1'b0, 32'h0);
      chk("wrap addr 0", acc_q[0], 32'hFFFF_FFFC);
      chk("wrap addr 1", acc_q[1], 32'h0000_0000);
      chk("wrap first pc4", pop_pc[0], 32'h0000_0000);
      chk("wrap first instr", pop_ins[0], mem_word(32'hFFFF_FFFC));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, tests %0d failed %0d", tests, fails);
      $fatal(1, "watchdog");
   end
endmodule
